// File: rtl/frame_renderer_if.sv
// frame_renderer_if: frame request, game-state inputs and pixel stream of the frame renderer
//   master: control/datapath side; drives start, grid, user_x, enemy_x, ship_health and
//           receives x, y, colour, plot, busy, done
//   slave : the renderer itself (opposite directions)
interface frame_renderer_if #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
);
    logic                      start;
    logic [WIDTH*HEIGHT-1:0]   grid;
    logic [7:0]                user_x;
    logic [7:0]                enemy_x;
    logic [3:0]                ship_health;
    logic [7:0]                x;
    logic [6:0]                y;
    logic [2:0]                colour;
    logic                      plot;
    logic                      busy;
    logic                      done;

    modport master (
        output start, grid, user_x, enemy_x, ship_health,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, grid, user_x, enemy_x, ship_health,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/frame_renderer.sv
// frame_renderer: raster-scans game state and emits one pixel per clock to the VGA adapter
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of frame_renderer_if
//           in : start (frame request), grid (bullet bitmap, bit y*WIDTH+x),
//                user_x, enemy_x (sprite left x), ship_health (0..15)
//           out: x, y, colour (registered pixel), plot (write strobe),
//                busy (frame in progress), done (one-cycle end-of-frame pulse)
module frame_renderer #(
    parameter int         WIDTH    = 160,
    parameter int         HEIGHT   = 120,
    parameter int         SHIP_Y   = 112,
    parameter int         ENEMY_Y  = 2,
    parameter int         SPR_W    = 8,
    parameter int         SPR_H    = 6,
    parameter logic [2:0] C_SHIP   = 3'b010,
    parameter logic [2:0] C_ENEMY  = 3'b100,
    parameter logic [2:0] C_BULLET = 3'b111,
    parameter logic [2:0] C_HEALTH = 3'b110,
    parameter logic [2:0] C_BG     = 3'b000
) (
    input logic              clk,
    input logic              reset,
    frame_renderer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t      state, state_n;
    logic [7:0]  lx_q, ex_q, lx, ex, nx;
    logic [3:0]  hp_q, hp;
    logic [6:0]  ny;
    logic [14:0] idx;
    logic        last, ship_hit, enemy_hit, health_hit, bullet_hit;
    logic [2:0]  pix;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        last    = bus.x == 8'(WIDTH - 1) && bus.y == 7'(HEIGHT - 1);
        state_n = (state == IDLE && bus.start) ? DRAW :
                  (state == DRAW && last)      ? DONE :
                  (state == DONE)              ? IDLE : state;
        // coordinates of the pixel registered at the coming edge
        nx = (state == DRAW && bus.x != 8'(WIDTH - 1)) ? bus.x + 8'd1 : 8'd0;
        ny = (state != DRAW) ? 7'd0 : (bus.x == 8'(WIDTH - 1)) ? bus.y + 7'd1 : bus.y;
        // pixel (0,0) is rendered on the same edge that latches, so take the live inputs then
        lx = (state == IDLE) ? bus.user_x      : lx_q;
        ex = (state == IDLE) ? bus.enemy_x     : ex_q;
        hp = (state == IDLE) ? bus.ship_health : hp_q;
        // 9-bit right edge: sprites past the last column are clipped, never wrapped
        ship_hit   = nx >= lx && {1'b0, nx} <= {1'b0, lx} + 9'(SPR_W - 1) &&
                     ny >= 7'(SHIP_Y) && ny <= 7'(SHIP_Y + SPR_H - 1);
        enemy_hit  = nx >= ex && {1'b0, nx} <= {1'b0, ex} + 9'(SPR_W - 1) &&
                     ny >= 7'(ENEMY_Y) && ny <= 7'(ENEMY_Y + SPR_H - 1);
        health_hit = ny == 7'd0 && nx < {2'b00, hp, 2'b00};
        idx        = 15'(ny) * 15'(WIDTH) + 15'(nx);
        bullet_hit = bus.grid[idx];
        pix = ship_hit   ? C_SHIP   :
              enemy_hit  ? C_ENEMY  :
              health_hit ? C_HEALTH :
              bullet_hit ? C_BULLET : C_BG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= C_BG;
            bus.plot   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            lx_q       <= '0;
            ex_q       <= '0;
            hp_q       <= '0;
        end else begin
            bus.plot <= state_n == DRAW;
            bus.busy <= state_n == DRAW;
            bus.done <= state == DRAW && state_n == DONE;
            if (state_n == DRAW) begin
                bus.x      <= nx;
                bus.y      <= ny;
                bus.colour <= pix;
            end
            if (state == IDLE && bus.start) begin
                lx_q <= bus.user_x;
                ex_q <= bus.enemy_x;
                hp_q <= bus.ship_health;
            end
        end
    end
endmodule

// File: tb/tb_frame_renderer.sv
// tb_frame_renderer: scoreboard bench for frame_renderer
module tb_frame_renderer;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic reset = 1'b1;

    frame_renderer_if bus ();

    frame_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int frame_plots = 0;
    logic [17:0] sb [$];
    logic [2:0]  fb [256][128];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model(input int px, input int py, input int ux, input int ex, input int hp);
        if (px >= ux && px <= ux + 7 && py >= 112 && py <= 117) return 3'b010;
        if (px >= ex && px <= ex + 7 && py >= 2 && py <= 7) return 3'b100;
        if (py == 0 && px < 4 * hp) return 3'b110;
        if (bus.grid[15'(py * W + px)]) return 3'b111;
        return 3'b000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fbchk(input string tag, input logic [7:0] px, input logic [6:0] py, input logic [2:0] exp);
        check(tag, 32'(fb[px][py]), 32'(exp));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.done) done_cnt++;
        if (bus.plot) begin
            frame_plots++;
            fb[bus.x][bus.y] = bus.colour;
            check("sb_avail", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("pixel", 32'({bus.x, bus.y, bus.colour}), 32'(sb.pop_front()));
        end
    end

    task automatic launch(input logic [7:0] ux, input logic [7:0] ex, input logic [3:0] hp);
        bus.user_x = ux;
        bus.enemy_x = ex;
        bus.ship_health = hp;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                sb.push_back({8'(xx), 7'(yy), model(xx, yy, int'(ux), int'(ex), int'(hp))});
        frame_plots = 0;
        bus.start = 1'b1;
        start_cyc = cyc;
        tick();
        bus.start = 1'b0;
        // scrambled inputs must not affect a frame in progress
        bus.user_x = 8'hAA;
        bus.enemy_x = 8'h55;
        bus.ship_health = 4'h7;
        check("first_plot", 32'({bus.plot, bus.busy, bus.x, bus.y}), 32'({1'b1, 1'b1, 8'd0, 7'd0}));
    endtask

    task automatic finish_frame(input int poke);
        for (int k = 0; k < N + 100; k++) begin
            if (bus.done) break;
            tick();
            bus.start = (poke > 0 && cyc - start_cyc == poke);
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("latency", 32'(cyc - start_cyc), 32'(N + 1));
        check("plot_count", 32'(frame_plots), 32'(N));
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("done_idle", 32'({bus.plot, bus.busy}), 32'd0);
        check("hold_xy", 32'({bus.x, bus.y}), 32'({8'd159, 7'd119}));
    endtask

    initial begin
        int dc;
        int fp;
        bus.start = 1'b0;
        bus.grid = '0;
        bus.user_x = 8'd0;
        bus.enemy_x = 8'd0;
        bus.ship_health = 4'd0;
        tick();
        tick();
        check("reset_state", 32'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 32'd0);
        reset = 1'b0;
        tick();

        // empty frame with sprites
        launch(8'd10, 8'd80, 4'd0);
        finish_frame(0);
        tick();
        check("done_single", 32'(bus.done), 32'd0);
        fbchk("ship_tl", 8'd10, 7'd112, 3'b010);
        fbchk("ship_br", 8'd17, 7'd117, 3'b010);
        fbchk("enemy_tl", 8'd80, 7'd2, 3'b100);
        fbchk("enemy_br", 8'd87, 7'd7, 3'b100);
        fbchk("ship_left_out", 8'd9, 7'd112, 3'b000);
        fbchk("ship_right_out", 8'd18, 7'd112, 3'b000);

        // reset in the middle of a frame
        launch(8'd10, 8'd80, 4'd0);
        for (int k = 0; k < 5000 && !(bus.x == 8'd37 && bus.y == 7'd20); k++) tick();
        check("reach_37_20", 32'({bus.x, bus.y}), 32'({8'd37, 7'd20}));
        dc = done_cnt;
        reset = 1'b1;
        #1;
        check("rst_mid_out", 32'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 32'd0);
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        fp = frame_plots;
        repeat (20) tick();
        check("rst_no_done", 32'(done_cnt), 32'(dc));
        check("rst_no_plot", 32'(frame_plots), 32'(fp));
        check("rst_idle", 32'({bus.plot, bus.busy}), 32'd0);

        // bullets and priority, with ignored start pulses mid-frame and on done
        bus.grid[15'(50 * W + 5)] = 1'b1;
        bus.grid[15'(114 * W + 12)] = 1'b1;
        launch(8'd10, 8'd80, 4'd0);
        finish_frame(100);
        bus.start = 1'b1;
        fbchk("bullet", 8'd5, 7'd50, 3'b111);
        fbchk("ship_over_bullet", 8'd12, 7'd114, 3'b010);
        tick();
        check("after_done", 32'({bus.done, bus.plot}), 32'd0);

        // clipping and health bar, started the cycle after done
        launch(8'd156, 8'd80, 4'd15);
        finish_frame(0);
        fbchk("clip_l", 8'd156, 7'd112, 3'b010);
        fbchk("clip_r", 8'd159, 7'd117, 3'b010);
        fbchk("no_wrap", 8'd0, 7'd112, 3'b000);
        fbchk("no_wrap2", 8'd3, 7'd117, 3'b000);
        fbchk("health_0", 8'd0, 7'd0, 3'b110);
        fbchk("health_59", 8'd59, 7'd0, 3'b110);
        fbchk("health_60", 8'd60, 7'd0, 3'b000);
        fbchk("bullet_keep", 8'd5, 7'd50, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
